// File: rtl/ps2_effect_entry.sv
// Numeric entry for effect channels from a PS/2 keyboard byte stream.
// Digits accumulate per channel request and are clamped to MAX_VAL on commit.
module ps2_effect_entry #(
    parameter int NUM_CH  = 3,
    parameter int CH_W    = 2,
    parameter int DIGITS  = 3,
    parameter int VAL_W   = 7,
    parameter int MAX_VAL = 100,
    parameter int ACC_W   = 10,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [7:0]                 ps2_key_data,
    input  logic                       ps2_key_pressed,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic [NUM_CH-1:0]          ch_req,
    output logic [NUM_CH*VAL_W-1:0]    ch_value,
    output logic                       update_valid,
    output logic [CH_W-1:0]            update_ch,
    output logic                       clamped,
    output logic                       aborted,
    output logic                       busy,
    output logic [$clog2(DIGITS+1)-1:0] digit_count,
    output logic [1:0]                 state
);

    localparam int DC_W = $clog2(DIGITS+1);
    localparam int TM_W = $clog2(TIMEOUT+1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2,
        ABORT  = 2'd3
    } state_t;

    state_t                    r_state;
    logic [NUM_CH*VAL_W-1:0]   r_chValue;
    logic                      r_updateValid;
    logic [CH_W-1:0]           r_updateCh;
    logic                      r_clamped;
    logic                      r_aborted;
    logic                      r_busy;
    logic [DC_W-1:0]           r_digitCount;
    logic [ACC_W-1:0]          r_acc;
    logic                      r_break;
    logic [TM_W-1:0]           r_timer;

    logic [NUM_CH-1:0]         w_reqHit;
    logic [CH_W-1:0]           w_reqIdx;
    logic                      w_isDigit;
    logic [3:0]                w_digit;
    logic [ACC_W-1:0]          w_accMul;
    logic [ACC_W-1:0]          w_accDiv;
    logic                      w_overMax;
    logic [VAL_W-1:0]          w_commitVal;
    logic                      w_curEn;
    logic                      w_keyLive;

    // Lowest-index enabled requester wins.
    always_comb begin
        w_reqHit = ch_req & ch_en;
        w_reqIdx = '0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            if (w_reqHit[i]) w_reqIdx = CH_W'(i);
        end
    end

    always_comb begin
        w_isDigit = 1'b1;
        w_digit   = 4'd0;
        case (ps2_key_data)
            8'h45: w_digit = 4'd0;
            8'h16: w_digit = 4'd1;
            8'h1E: w_digit = 4'd2;
            8'h26: w_digit = 4'd3;
            8'h25: w_digit = 4'd4;
            8'h2E: w_digit = 4'd5;
            8'h36: w_digit = 4'd6;
            8'h3D: w_digit = 4'd7;
            8'h3E: w_digit = 4'd8;
            8'h46: w_digit = 4'd9;
            default: w_isDigit = 1'b0;
        endcase
    end

    assign w_accMul    = (r_acc << 3) + (r_acc << 1) + {{(ACC_W-4){1'b0}}, w_digit};
    assign w_accDiv    = r_acc / ACC_W'(10);
    assign w_overMax   = r_acc > ACC_W'(MAX_VAL);
    assign w_commitVal = w_overMax ? VAL_W'(MAX_VAL) : r_acc[VAL_W-1:0];
    assign w_curEn     = ch_en[r_updateCh];
    // A byte following F0h is a release code and must not act as a key.
    assign w_keyLive   = ps2_key_pressed && !r_break && (ps2_key_data != 8'hF0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_chValue     <= '0;
            r_updateValid <= 1'b0;
            r_updateCh    <= '0;
            r_clamped     <= 1'b0;
            r_aborted     <= 1'b0;
            r_busy        <= 1'b0;
            r_digitCount  <= '0;
            r_acc         <= '0;
            r_break       <= 1'b0;
            r_timer       <= '0;
        end else begin
            r_updateValid <= 1'b0;
            r_clamped     <= 1'b0;
            r_aborted     <= 1'b0;

            if (ps2_key_pressed) begin
                r_timer <= '0;
                if (r_break)                     r_break <= 1'b0;
                else if (ps2_key_data == 8'hF0)  r_break <= 1'b1;
            end else if (r_state == ENTRY) begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (|w_reqHit) begin
                        r_state      <= ENTRY;
                        r_busy       <= 1'b1;
                        r_updateCh   <= w_reqIdx;
                        r_acc        <= '0;
                        r_digitCount <= '0;
                        r_break      <= 1'b0;
                        r_timer      <= '0;
                    end
                end
                ENTRY: begin
                    // Losing the channel enable overrides any key arriving this cycle.
                    if (!w_curEn) begin
                        r_state <= ABORT;
                    end else if (w_keyLive) begin
                        if (w_isDigit) begin
                            if (r_digitCount < DC_W'(DIGITS)) begin
                                r_acc        <= w_accMul;
                                r_digitCount <= r_digitCount + 1'b1;
                            end
                        end else if (ps2_key_data == 8'h66) begin
                            if (r_digitCount != '0) begin
                                r_acc        <= w_accDiv;
                                r_digitCount <= r_digitCount - 1'b1;
                            end
                        end else if (ps2_key_data == 8'h5A) begin
                            r_state <= (r_digitCount != '0) ? COMMIT : ABORT;
                        end else if (ps2_key_data == 8'h76) begin
                            r_state <= ABORT;
                        end
                    end else if (!ps2_key_pressed && r_timer == TM_W'(TIMEOUT-1)) begin
                        r_state <= ABORT;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (r_updateCh == CH_W'(i)) r_chValue[i*VAL_W +: VAL_W] <= w_commitVal;
                    end
                    r_updateValid <= 1'b1;
                    r_clamped     <= w_overMax;
                    r_state       <= IDLE;
                    r_busy        <= 1'b0;
                end
                ABORT: begin
                    r_aborted <= 1'b1;
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ch_value     = r_chValue;
    assign update_valid = r_updateValid;
    assign update_ch    = r_updateCh;
    assign clamped      = r_clamped;
    assign aborted      = r_aborted;
    assign busy         = r_busy;
    assign digit_count  = r_digitCount;
    assign state        = r_state;

endmodule

// File: doc/ps2_effect_entry.md
PS2_EFFECT_ENTRY -- requirements
Module: ps2_effect_entry

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of effect channels.
REQ-002 SHALL have parameter CH_W, default 2: channel-index width, at least clog2(NUM_CH).
REQ-003 SHALL have parameter DIGITS, default 3: maximum decimal digits per entry.
REQ-004 SHALL have parameter VAL_W, default 7: stored value width.
REQ-005 SHALL have parameter MAX_VAL, default 100: clamp ceiling, at most 2^VAL_W-1.
REQ-006 SHALL have parameter ACC_W, default 10: accumulator width, able to hold 10^DIGITS-1.
REQ-007 SHALL have parameter TIMEOUT, default 50_000_000: idle cycles before an entry aborts.
REQ-008 SHALL have ports:
- Clock  in  1  clock.
- Reset  in  1  synchronous, active-high.
- ps2_key_data  in  8  last PS/2 scan byte.
- ps2_key_pressed  in  1  one-cycle strobe per received byte.
- ch_en  in  NUM_CH  channel enabled.
- ch_req  in  NUM_CH  request to edit a channel.
- ch_value  out  NUM_CH*VAL_W  stored values, channel i at bits [i*VAL_W +: VAL_W].
- update_valid  out  1  one-cycle commit pulse.
- update_ch  out  CH_W  channel committed or being edited.
- clamped  out  1  one-cycle pulse, committed value was clamped.
- aborted  out  1  one-cycle pulse, entry discarded.
- busy  out  1  high in every state except IDLE.
- digit_count  out  clog2(DIGITS+1)  digits currently held.
- state  out  2  IDLE=0, ENTRY=1, COMMIT=2, ABORT=3.

Function
REQ-009 SHALL register all outputs.
REQ-010 In IDLE, SHALL move to ENTRY when any bit of (ch_req & ch_en) is set.
- Selects the lowest such index into update_ch.
- Clears the accumulator, digit_count and the break flag.
REQ-011 SHALL decode key codes 45,16,1E,26,25,2E,36,3D,3E,46 (hex) as digits 0-9.
REQ-012 In ENTRY, on a digit strobe with digit_count<DIGITS, acc <= acc*10+digit and digit_count++; when digit_count=DIGITS the digit is ignored.
REQ-013 In ENTRY, on 66h (backspace) with digit_count>0, acc <= acc/10 and digit_count--; with digit_count=0 it is ignored.
REQ-014 In ENTRY, on 5Ah (Enter), SHALL go to COMMIT if digit_count>0, else to ABORT.
REQ-015 In ENTRY, on 76h (Esc), SHALL go to ABORT.
REQ-016 On byte F0h, SHALL set the break flag; the next strobed byte then only clears the flag and has no other effect. Applies in all states.
REQ-017 All other codes SHALL be ignored.
REQ-018 SHALL keep a timeout counter that clears on every strobe and on entering ENTRY; reaching TIMEOUT-1 in ENTRY goes to ABORT.
REQ-019 If ch_en[update_ch] drops in ENTRY, SHALL go to ABORT; this takes priority over a same-cycle key strobe.
REQ-020 For the single cycle in COMMIT:
- ch_value slice update_ch = min(acc, MAX_VAL).
- update_valid=1.
- clamped=1 if acc>MAX_VAL.
- Next state is IDLE.
REQ-021 For the single cycle in ABORT: aborted=1, no ch_value change, next state IDLE.
REQ-022 Commit latency SHALL be exactly 1 cycle: Enter strobed at edge N gives state=COMMIT and the new ch_value visible after edge N+1.
REQ-023 ch_req SHALL be ignored outside IDLE; other channels' values SHALL never change during an entry.

Reset
REQ-024 Reset asserted at an edge, including mid-entry, SHALL:
- set state=IDLE;
- clear ch_value, acc, digit_count, the break flag and the timeout counter;
- set update_ch=0;
- deassert update_valid, clamped, aborted and busy.
REQ-025 Reset SHALL take priority over all other inputs.

Verification
REQ-026 ch_req=001, keys 16,45,45,5A (Enter) -> update_valid 1 cycle, ch_value[6:0]=100, clamped=0.
REQ-027 ch_req=010, keys 46,46,46,5A -> ch_value[13:7]=100, clamped=1.
REQ-028 ch_req=100, keys 26,25,66,2E,5A -> ch_value[20:14]=35.
REQ-029 ch_req=001, keys 1E,F0,1E,5A -> value=2 (the break byte after F0h is ignored).
REQ-030 ch_req=110 -> update_ch=1; drop ch_en[1] mid-entry, or wait TIMEOUT cycles -> aborted pulse, values unchanged.
REQ-031 Reset asserted after 2 digits -> state=0, busy=0, all ch_value=0; a subsequent 5Ah has no effect.
